// File: rtl/mux_4_to_1.sv
// -----------------------------------------------------------------------------
// mux_4_to_1
//
// Registered 4-input, WIDTH-bit multiplexer for the CPU datapath. One of the
// four buses A/B/C/D is chosen by `sel` and captured into `out` on every
// enabled rising clock edge. `valid` marks that `out` holds a captured value
// since reset, and `changed` pulses for one cycle when the last capture
// altered `out`.
//
// Optional feature: define MUX_4_TO_1_PARITY_EN to add a registered `parity`
// output holding the XOR-reduction of the captured value.
//
// Parameters:
//   WIDTH      data width of A/B/C/D and out (default 8)
//   RESET_VAL  value loaded into out on reset (default 0)
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   en       in   1      capture enable; low holds all registered outputs
//   sel      in   2      00->A, 01->B, 10->C, 11->D
//   A,B,C,D  in   WIDTH  data inputs 0..3
//   out      out  WIDTH  registered selected data
//   sel_q    out  2      select captured together with out
//   valid    out  1      out holds a captured value since reset
//   changed  out  1      one-cycle pulse when the last capture altered out
//   parity   out  1      (MUX_4_TO_1_PARITY_EN only) XOR-reduction of out
// -----------------------------------------------------------------------------
module mux_4_to_1 #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       sel_q,
    output logic             valid,
    output logic             changed
`ifdef MUX_4_TO_1_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [WIDTH-1:0] mux_d;

    logic [WIDTH-1:0] out_d,     out_q;
    logic [1:0]       sel_reg_d, sel_reg_q;
    logic             valid_d,   valid_q;
    logic             changed_d, changed_q;

`ifdef MUX_4_TO_1_PARITY_EN
    logic             parity_d,  parity_q;

    // Even-parity bit of a data word (1 when an odd number of bits are set).
    function automatic logic parity_of(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction
`endif

    // Input selection, fully decoded so every sel value yields a known bus.
    always_comb begin
        mux_d = A;
        case (sel)
            2'b00:   mux_d = A;
            2'b01:   mux_d = B;
            2'b10:   mux_d = C;
            2'b11:   mux_d = D;
            default: mux_d = A;
        endcase
    end

    // Next-state logic: capture on enable, otherwise hold and drop changed.
    always_comb begin
        out_d     = out_q;
        sel_reg_d = sel_reg_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
`ifdef MUX_4_TO_1_PARITY_EN
        parity_d  = parity_q;
`endif
        if (en) begin
            out_d     = mux_d;
            sel_reg_d = sel;
            valid_d   = 1'b1;
            // Compared against the value out held before this edge.
            changed_d = (mux_d != out_q);
`ifdef MUX_4_TO_1_PARITY_EN
            parity_d  = parity_of(mux_d);
`endif
        end else begin
            changed_d = 1'b0;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= RESET_VAL;
            sel_reg_q <= 2'b00;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
`ifdef MUX_4_TO_1_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            out_q     <= out_d;
            sel_reg_q <= sel_reg_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
`ifdef MUX_4_TO_1_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign out     = out_q;
    assign sel_q   = sel_reg_q;
    assign valid   = valid_q;
    assign changed = changed_q;
`ifdef MUX_4_TO_1_PARITY_EN
    assign parity  = parity_q;
`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
module tb_mux_4_to_1;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   sel;
    logic [W-1:0] A, B, C, D;
    logic [W-1:0] out;
    logic [1:0]   sel_q;
    logic         valid;
    logic         changed;
`ifdef MUX_4_TO_1_PARITY_EN
    logic         parity;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_out;
    logic [1:0]   m_sel;
    logic         m_valid;
    logic         m_changed;

    mux_4_to_1 #(.WIDTH(W), .RESET_VAL(8'd0)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sel     (sel),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .out     (out),
        .sel_q   (sel_q),
        .valid   (valid),
        .changed (changed)
`ifdef MUX_4_TO_1_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_out     = 8'd0;
        m_sel     = 2'b00;
        m_valid   = 1'b0;
        m_changed = 1'b0;
    endtask

    // Advance one rising edge, update the model from the inputs seen at that
    // edge, then step 1 ns past the edge for sampling and new stimulus.
    task automatic tick();
        logic [W-1:0] bus [4];
        @(posedge clk);
        bus[0] = A; bus[1] = B; bus[2] = C; bus[3] = D;
        if (!rst) begin
            if (en) begin
                m_changed = (bus[sel] != m_out);
                m_out     = bus[sel];
                m_sel     = sel;
                m_valid   = 1'b1;
            end else begin
                m_changed = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sel = 2'b00;
        A = 8'd1; B = 8'd2; C = 8'd3; D = 8'd0;
        #1;
        model_reset();
        checks++;
        if ({out, sel_q, valid, changed} !== {8'd0, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_initial: got out=%0d sel_q=%0d valid=%0b changed=%0b, want 0/0/0/0",
                     out, sel_q, valid, changed);
        end
        #7 rst = 1'b0;
        // Capture out=3 then assert reset mid-cycle
        en = 1'b1; sel = 2'b10;
        tick();
        checks++;
        if (out !== 8'd3) begin
            errors++;
            $display("FAIL reset_precap: got out=%0d, want 3", out);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({out, sel_q, valid, changed} !== {8'd0, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got out=%0d sel_q=%0d valid=%0b changed=%0b, want 0/0/0/0",
                     out, sel_q, valid, changed);
        end
        // Reset wins over enable at a clock edge
        tick();
        checks++;
        if ({out, valid} !== {8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_wins: got out=%0d valid=%0b, want 0/0", out, valid);
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_sweep();
        A = 8'd1; B = 8'd2; C = 8'd3; D = 8'd0; en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = s[1:0];
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++;
                if ({out, sel_q, valid, changed} !== {m_out, m_sel, m_valid, m_changed}) begin
                    errors++;
                    $display("FAIL sweep sel=%0d edge=%0d: got out=%0d sel_q=%0d valid=%0b changed=%0b, want %0d/%0d/%0b/%0b",
                             s, k, out, sel_q, valid, changed, m_out, m_sel, m_valid, m_changed);
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        A = 8'd1; B = 8'd2; C = 8'd3; D = 8'd0;
        en = 1'b1; sel = 2'b01;
        tick();
        tick();
        checks++;
        if (out !== 8'd2) begin
            errors++;
            $display("FAIL hold_setup: got out=%0d, want 2", out);
        end
        en = 1'b0; sel = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({out, sel_q, changed} !== {8'd2, 2'b01, 1'b0}) begin
                errors++;
                $display("FAIL hold_en0: got out=%0d sel_q=%0d changed=%0b, want 2/1/0", out, sel_q, changed);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if ({out, sel_q, changed} !== {8'd3, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL hold_resume: got out=%0d sel_q=%0d changed=%0b, want 3/2/1", out, sel_q, changed);
        end
    endtask

    task automatic test_equal_values();
        A = 8'd5; B = 8'd5; en = 1'b1; sel = 2'b00;
        tick();
        tick();
        sel = 2'b01;
        tick();
        checks++;
        if ({out, sel_q, changed} !== {8'd5, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL equal_values: got out=%0d sel_q=%0d changed=%0b, want 5/1/0", out, sel_q, changed);
        end
    endtask

    task automatic test_unselected();
        logic [W-1:0] c_val;
        c_val = W'($urandom_range(1, 255));
        C = c_val; sel = 2'b10; en = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            A = W'($urandom);
            D = W'($urandom);
            tick();
            checks++;
            if ({out, changed} !== {c_val, 1'b0}) begin
                errors++;
                $display("FAIL unselected k=%0d: got out=%0d changed=%0b, want %0d/0", k, out, changed, c_val);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            en  = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom);
            // Narrow data range makes equal-value captures common
            A = W'($urandom_range(0, 3));
            B = W'($urandom_range(0, 3));
            C = W'($urandom);
            D = W'($urandom_range(0, 3));
            tick();
            checks++;
            if ({out, sel_q, valid, changed} !== {m_out, m_sel, m_valid, m_changed}) begin
                errors++;
                $display("FAIL random k=%0d: got out=%0d sel_q=%0d valid=%0b changed=%0b, want %0d/%0d/%0b/%0b",
                         k, out, sel_q, valid, changed, m_out, m_sel, m_valid, m_changed);
            end
`ifdef MUX_4_TO_1_PARITY_EN
            checks++;
            if (parity !== (^m_out)) begin
                errors++;
                $display("FAIL random_parity k=%0d: got %0b, want %0b", k, parity, ^m_out);
            end
`endif
            // Occasional asynchronous reset between edges
            if ($urandom_range(0, 40) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                checks++;
                if ({out, sel_q, valid, changed} !== {8'd0, 2'b00, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL random_reset k=%0d: got out=%0d sel_q=%0d valid=%0b changed=%0b, want 0/0/0/0",
                             k, out, sel_q, valid, changed);
                end
                #1 rst = 1'b0;
            end
        end
    endtask

`ifdef MUX_4_TO_1_PARITY_EN
    task automatic test_parity();
        A = 8'h03; en = 1'b1; sel = 2'b00;
        tick();
        checks++;
        if (parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_03: got %0b, want 0", parity);
        end
        A = 8'h07;
        tick();
        checks++;
        if (parity !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: got %0b, want 1", parity);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_enable_hold();
        test_equal_values();
        test_unselected();
`ifdef MUX_4_TO_1_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_4_to_1.md
# mux_4_to_1

Registered 4-input, WIDTH-bit multiplexer used on the CPU datapath to choose one of four operand/result buses by a 2-bit select. One input is routed to `out` on each enabled clock edge; a `valid` flag and a one-cycle `changed` pulse tell downstream logic when the selected value is fresh. All state is cleared by an asynchronous active-high reset.

## Interface
- `WIDTH`, default 8: data width of every input bus and of `out`.
- `RESET_VAL`, default 0: value loaded into `out` on reset.
- `clk`  input  1  rising-edge clock for all registers.
- `rst`  input  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high.
- `en`  input  1  capture enable; when low, all registered outputs hold.
- `sel`  input  2  select: 00→A, 01→B, 10→C, 11→D.
- `A`  input  WIDTH  data input 0.
- `B`  input  WIDTH  data input 1.
- `C`  input  WIDTH  data input 2.
- `D`  input  WIDTH  data input 3.
- `out`  output  WIDTH  registered selected data.
- `sel_q`  output  2  select value captured with `out`.
- `valid`  output  1  high once `out` holds a captured value since reset.
- `changed`  output  1  one-cycle pulse when the last capture altered `out`.

## Operation
- Combinational selection `mux_d` = A/B/C/D per `sel`, fully decoded; no X or latch for any 2-bit `sel`.
- On rising `clk` with `en`=1: `out` ← `mux_d`, `sel_q` ← `sel`, `valid` ← 1, `changed` ← (`mux_d` != `out`).
- On rising `clk` with `en`=0: `out`, `sel_q`, `valid` hold; `changed` ← 0.
- `changed` compares against the pre-edge `out`; selecting a different input carrying an equal value gives `changed`=0.
- Inputs are not registered; only the selected bus at the edge matters. Changes to unselected inputs have no effect.
- All widths equal WIDTH; no extension or truncation.

## Timing
- Latency: exactly 1 clock from `sel`/data at an enabled edge to `out`.
- Reset (asserted any time, including mid-stream): immediately, without clock, `out`=RESET_VAL, `sel_q`=00, `valid`=0, `changed`=0 (`parity`=0 when built in).
- Reset release: first enabled edge after `rst` falls captures normally; `changed` on that edge compares against RESET_VAL.
- `rst` and `en` high together: reset wins.
- `sel` change between edges: no visible effect until the next enabled edge.
- `changed` is never high for two consecutive cycles unless two consecutive enabled captures each altered `out`.

## Configuration
- Macro `MUX_4_TO_1_PARITY_EN`.
- Defined: extra output port `parity` (output, 1 bit) registered alongside `out`, equal to XOR-reduction of the captured value; reset 0; holds when `en`=0.
- Not defined: `parity` port and its logic are absent; all other behaviour identical.

## Test plan
- Reset: assert `rst` mid-cycle with `out`=3 → `out`=0, `sel_q`=00, `valid`=0, `changed`=0 immediately, before any clock edge.
- Sweep: A=1, B=2, C=3, D=0, `en`=1, `sel` 00,01,10,11 held 30 ns each (10 ns clock) → `out` 1,2,3,0 one edge after each change; `changed` pulses once per change; `valid`=1 after first edge.
- Enable hold: `sel`=01 captured (`out`=2), then `en`=0, `sel`=10 → `out` stays 2, `changed`=0; `en`=1 → `out`=3 next edge.
- Equal values: A=5, B=5, switch `sel` 00→01 → `out` stays 5, `sel_q`=01, `changed`=0.
- Unselected input: `sel`=10, toggle A and D repeatedly → `out`=C unchanged, `changed`=0.
- Parity (macro defined): captures of 8'h03, 8'h07 → `parity`=0 then 1; macro undefined → build has no `parity` port.
